mwb_pipe: RTL and testbench
===========================

Name: mwb_pipe

Overview:
- Parametrised MEM→WB pipeline register, successor to the fixed single-stage MEM/WB latch.
- Adds configurable stage count, per-stage valid bit, stall (hold) and flush (squash) control.
- Adds a registered writeback result mux, a qualified register-file write enable, and an in-flight occupancy count.
- Sits between data-memory access and register-file writeback in the 5-stage CPU.

Parameters:
- DATA_W, 32, width of ALU result / memory data.
- REG_AW, 5, register-file address width.
- STAGES, 1, number of pipeline register stages, legal 1..4; any other value is an elaboration error.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- stall  input  1  hold all stages
- flush  input  1  squash all stages
- mvalid  input  1  MEM-stage instruction valid
- mwreg  input  1  write result to register
- mm2reg  input  1  result comes from memory (load)
- mdestreg  input  REG_AW  destination register
- mr  input  DATA_W  ALU result / data-memory address
- mdo  input  DATA_W  data read from data memory
- wvalid  output  1  WB-stage instruction valid
- wwreg  output  1  registered write flag
- wm2reg  output  1  registered load flag
- wdestreg  output  REG_AW  registered destination
- wr  output  DATA_W  registered ALU result
- wdo  output  DATA_W  registered memory data
- wdata  output  DATA_W  writeback value: wdo when wm2reg, else wr (combinational from last stage)
- we  output  1  wvalid & wwreg & (wdestreg != 0)
- inflight  output  clog2(STAGES+1)  count of valid stages

Behaviour:
- Reset (async, rst=1): every stage's valid, wreg, m2reg, destreg, r and do clear to 0. Outputs then read: wvalid=0, wwreg=0, wm2reg=0, wdestreg=0, wr=0, wdo=0, wdata=0, we=0, inflight=0.
- Reset release: first capture on the first rising edge with rst=0.
- Normal operation (stall=0, flush=0): stage 0 captures the m* inputs; stage k captures stage k-1. Outputs are the last stage. Latency is exactly STAGES cycles.
- Bubble masking: when mvalid=0, stage 0 loads valid=0, wreg=0, m2reg=0; destreg, r and do are still captured (don't-care).
- Stall (stall=1, flush=0): all stages hold, including data fields. inflight holds.
- Flush (flush=1): on the edge, every stage clears valid, wreg and m2reg; data fields hold. The m* inputs that cycle are discarded.
- stall and flush both asserted: flush wins.
- Flush/stall occurring mid-operation: no partial effect; applies uniformly to all stages on the same edge.
- inflight: registered popcount of the stage valid bits, updated on the same edge as the stages.
  - Equals STAGES when full, 0 when empty; never wraps.
  - Flush forces 0.
- we: suppressed for writes to register 0 even when valid and wreg are set.

Optional Feature:
- Macro: MWB_HAZARD_EN.
- Defined: adds input ports rs and rt (REG_AW each) and output ports hit_rs and hit_rt (1 each).
  - hit_rs = OR over all stages of (valid & wreg & destreg==rs & destreg!=0); hit_rt likewise with rt.
  - Purely combinational from stage state; used by the decode-stage interlock.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-run: STAGES=2, rst pulsed asynchronously between edges while 2 valid ops are in flight → all outputs 0 immediately and inflight=0 before the next edge.
- Load path: STAGES=1, mvalid=1, mwreg=1, mm2reg=1, mdestreg=8, mr=0x100, mdo=0xDEADBEEF → next edge: wdata=0xDEADBEEF, we=1, wdestreg=8.
- Latency and occupancy: STAGES=3, ALU ops destreg 1, 2, 3 issued back-to-back with mr=0x11, 0x22, 0x33 → wr=0x11 appears on the 3rd edge, then 0x22, then 0x33; inflight steps 1, 2, 3.
- Stall then flush: STAGES=2, full pipe, stall=1 for 2 cycles → outputs unchanged; then stall=1 and flush=1 together → wvalid=0, we=0, inflight=0, wr keeps its old value.
- Register-0 write: mvalid=1, mwreg=1, mdestreg=0, mr=0x5 → wvalid=1, wwreg=1, we=0.
- Hazard compare (MWB_HAZARD_EN, STAGES=2): valid write to register 9 in stage 0, rs=9, rt=4 → hit_rs=1, hit_rt=0; after a flush → hit_rs=0.

Source files
------------

// File: rtl/mwb_pipe.sv
// MEM->WB pipeline register with configurable depth, stall/flush, writeback mux and occupancy count.
// Optional decode-stage hazard compare ports are enabled by defining MWB_HAZARD_EN.
module mwb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int STAGES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         mvalid,
  input  logic                         mwreg,
  input  logic                         mm2reg,
  input  logic [REG_AW-1:0]            mdestreg,
  input  logic [DATA_W-1:0]            mr,
  input  logic [DATA_W-1:0]            mdo,
  output logic                         wvalid,
  output logic                         wwreg,
  output logic                         wm2reg,
  output logic [REG_AW-1:0]            wdestreg,
  output logic [DATA_W-1:0]            wr,
  output logic [DATA_W-1:0]            wdo,
  output logic [DATA_W-1:0]            wdata,
  output logic                         we,
  output logic [$clog2(STAGES+1)-1:0]  inflight
`ifdef MWB_HAZARD_EN
  ,
  input  logic [REG_AW-1:0]            rs,
  input  logic [REG_AW-1:0]            rt,
  output logic                         hit_rs,
  output logic                         hit_rt
`endif
);

  localparam int CNT_W = $clog2(STAGES + 1);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("mwb_pipe: STAGES must be in 1..4");
    end
  endgenerate

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] wreg_q,  wreg_d;
  logic [STAGES-1:0] m2reg_q, m2reg_d;
  logic [REG_AW-1:0] dest_q [STAGES];
  logic [REG_AW-1:0] dest_d [STAGES];
  logic [DATA_W-1:0] r_q    [STAGES];
  logic [DATA_W-1:0] r_d    [STAGES];
  logic [DATA_W-1:0] do_q   [STAGES];
  logic [DATA_W-1:0] do_d   [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Stage advance: flush clears control bits only, stall holds everything, else shift.
  always_comb begin
    valid_d = valid_q;
    wreg_d  = wreg_q;
    m2reg_d = m2reg_q;
    dest_d  = dest_q;
    r_d     = r_q;
    do_d    = do_q;
    if (flush) begin
      valid_d = '0;
      wreg_d  = '0;
      m2reg_d = '0;
    end else if (!stall) begin
      // Bubbles still capture data fields; only control bits are masked.
      valid_d[0] = mvalid;
      wreg_d[0]  = mvalid & mwreg;
      m2reg_d[0] = mvalid & mm2reg;
      dest_d[0]  = mdestreg;
      r_d[0]     = mr;
      do_d[0]    = mdo;
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        wreg_d[k]  = wreg_q[k-1];
        m2reg_d[k] = m2reg_q[k-1];
        dest_d[k]  = dest_q[k-1];
        r_d[k]     = r_q[k-1];
        do_d[k]    = do_q[k-1];
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Occupancy is the popcount of the next valid vector, so it tracks the stages exactly.
  always_comb begin
    cnt_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      cnt_d = cnt_d + CNT_W'(valid_d[k]);
    end
  end

  // Stage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wreg_q  <= '0;
      m2reg_q <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dest_q[k] <= '0;
        r_q[k]    <= '0;
        do_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wreg_q  <= wreg_d;
      m2reg_q <= m2reg_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        dest_q[k] <= dest_d[k];
        r_q[k]    <= r_d[k];
        do_q[k]   <= do_d[k];
      end
    end
  end

  assign wvalid   = valid_q[STAGES-1];
  assign wwreg    = wreg_q[STAGES-1];
  assign wm2reg   = m2reg_q[STAGES-1];
  assign wdestreg = dest_q[STAGES-1];
  assign wr       = r_q[STAGES-1];
  assign wdo      = do_q[STAGES-1];
  assign inflight = cnt_q;

  // Writeback mux and register-0 suppressed write enable.
  always_comb begin
    if (wm2reg) begin
      wdata = wdo;
    end else begin
      wdata = wr;
    end
    we = wvalid & wwreg & (wdestreg != {REG_AW{1'b0}});
  end

`ifdef MWB_HAZARD_EN
  // Any in-flight valid write to a nonzero register matching a decode source.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (valid_q[k] && wreg_q[k] && (dest_q[k] != {REG_AW{1'b0}})) begin
        hit_rs = hit_rs | (dest_q[k] == rs);
        hit_rt = hit_rt | (dest_q[k] == rt);
      end else begin
        hit_rs = hit_rs;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mwb_pipe.sv
// Scoreboard bench for mwb_pipe: three depths (1,2,3) share one stimulus stream.
module tb_mwb_pipe;

  logic        clk = 1'b0;
  logic        rst, stall, flush, mvalid, mwreg, mm2reg;
  logic [4:0]  mdestreg;
  logic [31:0] mr, mdo;

  logic        v1, ww1, wm1, we1, v2, ww2, wm2, we2, v3, ww3, wm3, we3;
  logic [4:0]  d1, d2, d3;
  logic [31:0] r1, o1, wd1, r2, o2, wd2, r3, o3, wd3;
  logic [0:0]  n1;
  logic [1:0]  n2, n3;
`ifdef MWB_HAZARD_EN
  logic [4:0]  rs, rt;
  logic        h1s, h1t, h2s, h2t, h3s, h3t;
`endif

  mwb_pipe #(.DATA_W(32), .REG_AW(5), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mvalid(mvalid), .mwreg(mwreg),
    .mm2reg(mm2reg), .mdestreg(mdestreg), .mr(mr), .mdo(mdo), .wvalid(v1), .wwreg(ww1),
    .wm2reg(wm1), .wdestreg(d1), .wr(r1), .wdo(o1), .wdata(wd1), .we(we1), .inflight(n1)
`ifdef MWB_HAZARD_EN
    , .rs(rs), .rt(rt), .hit_rs(h1s), .hit_rt(h1t)
`endif
  );

  mwb_pipe #(.DATA_W(32), .REG_AW(5), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mvalid(mvalid), .mwreg(mwreg),
    .mm2reg(mm2reg), .mdestreg(mdestreg), .mr(mr), .mdo(mdo), .wvalid(v2), .wwreg(ww2),
    .wm2reg(wm2), .wdestreg(d2), .wr(r2), .wdo(o2), .wdata(wd2), .we(we2), .inflight(n2)
`ifdef MWB_HAZARD_EN
    , .rs(rs), .rt(rt), .hit_rs(h2s), .hit_rt(h2t)
`endif
  );

  mwb_pipe #(.DATA_W(32), .REG_AW(5), .STAGES(3)) u3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mvalid(mvalid), .mwreg(mwreg),
    .mm2reg(mm2reg), .mdestreg(mdestreg), .mr(mr), .mdo(mdo), .wvalid(v3), .wwreg(ww3),
    .wm2reg(wm3), .wdestreg(d3), .wr(r3), .wdo(o3), .wdata(wd3), .we(we3), .inflight(n3)
`ifdef MWB_HAZARD_EN
    , .rs(rs), .rt(rt), .hit_rs(h3s), .hit_rt(h3t)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          v;
    bit          ww;
    bit          wm;
    bit          we;
    logic [4:0]  d;
    logic [31:0] wd;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];
  exp_t se;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_cmp(input string t, input exp_t e, input logic v, input logic ww,
                        input logic wm, input logic we_, input logic [4:0] d,
                        input logic [31:0] wd);
    chk({t, ".wvalid"}, 64'(v), 64'(e.v));
    chk({t, ".we"}, 64'(we_), 64'(e.we));
    if (e.v) begin
      chk({t, ".wwreg"}, 64'(ww), 64'(e.ww));
      chk({t, ".wm2reg"}, 64'(wm), 64'(e.wm));
      chk({t, ".wdestreg"}, 64'(d), 64'(e.d));
      chk({t, ".wdata"}, 64'(wd), 64'(e.wd));
    end
  endtask

  // Drive one MEM-stage slot at the falling edge; optionally record its expected WB result.
  task automatic drv(input bit v, input bit w, input bit m2, input logic [4:0] d,
                     input logic [31:0] r, input logic [31:0] dd, input bit push);
    exp_t e;
    @(negedge clk);
    mvalid = v; mwreg = w; mm2reg = m2; mdestreg = d; mr = r; mdo = dd;
    if (push) begin
      e.v  = v;
      e.ww = v & w;
      e.wm = v & m2;
      e.we = v & w & (d != 5'd0);
      e.d  = d;
      e.wd = m2 ? dd : r;
      e.due = cyc + 1; q1.push_back(e);
      e.due = cyc + 2; q2.push_back(e);
      e.due = cyc + 3; q3.push_back(e);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (q1.size() > 0 && q1[0].due == cyc) begin se = q1.pop_front(); sb_cmp("sb1", se, v1, ww1, wm1, we1, d1, wd1); end
    if (q2.size() > 0 && q2[0].due == cyc) begin se = q2.pop_front(); sb_cmp("sb2", se, v2, ww2, wm2, we2, d2, wd2); end
    if (q3.size() > 0 && q3[0].due == cyc) begin se = q3.pop_front(); sb_cmp("sb3", se, v3, ww3, wm3, we3, d3, wd3); end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mvalid = 1'b0; mwreg = 1'b0; mm2reg = 1'b0; mdestreg = 5'd0; mr = 32'd0; mdo = 32'd0;
`ifdef MWB_HAZARD_EN
    rs = 5'd0; rt = 5'd0;
`endif
    #12;
    chk("rst.wvalid2", 64'(v2), 64'd0);
    chk("rst.wr2", 64'(r2), 64'd0);
    chk("rst.wdo2", 64'(o2), 64'd0);
    chk("rst.wdata2", 64'(wd2), 64'd0);
    chk("rst.we2", 64'(we2), 64'd0);
    chk("rst.dest2", 64'(d2), 64'd0);
    chk("rst.inflight1", 64'(n1), 64'd0);
    chk("rst.inflight3", 64'(n3), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming through the scoreboard: idle, load, ALU ops, register-0 write.
    repeat (3) drv(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    drv(1'b1, 1'b1, 1'b1, 5'd8, 32'h100, 32'hDEADBEEF, 1'b1);
    repeat (3) drv(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    drv(1'b1, 1'b1, 1'b0, 5'd1, 32'h11, 32'd0, 1'b1);
    @(posedge clk); #1; chk("lat.inflight3_1", 64'(n3), 64'd1);
    drv(1'b1, 1'b1, 1'b0, 5'd2, 32'h22, 32'd0, 1'b1);
    @(posedge clk); #1; chk("lat.inflight3_2", 64'(n3), 64'd2);
    drv(1'b1, 1'b1, 1'b0, 5'd3, 32'h33, 32'd0, 1'b1);
    @(posedge clk); #1; chk("lat.inflight3_3", 64'(n3), 64'd3);
    chk("lat.wr3_first", 64'(r3), 64'h11);
    drv(1'b1, 1'b1, 1'b0, 5'd0, 32'h5, 32'd0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      drv(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 31)), $urandom, $urandom, 1'b1);
    end
    repeat (4) drv(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("sb.q1_empty", 64'(q1.size()), 64'd0);
    chk("sb.q2_empty", 64'(q2.size()), 64'd0);
    chk("sb.q3_empty", 64'(q3.size()), 64'd0);

    // Stall then stall+flush on a full two-stage pipe.
    drv(1'b1, 1'b1, 1'b0, 5'd5, 32'hA1, 32'd0, 1'b0);
    drv(1'b1, 1'b1, 1'b0, 5'd6, 32'hA2, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("full.wvalid2", 64'(v2), 64'd1);
    chk("full.wr2", 64'(r2), 64'hA1);
    chk("full.inflight2", 64'(n2), 64'd2);
    @(negedge clk);
    stall = 1'b1; mvalid = 1'b1; mwreg = 1'b1; mdestreg = 5'd7; mr = 32'hFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("stall.wr2", 64'(r2), 64'hA1);
      chk("stall.dest2", 64'(d2), 64'd5);
      chk("stall.we2", 64'(we2), 64'd1);
      chk("stall.inflight2", 64'(n2), 64'd2);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush.wvalid2", 64'(v2), 64'd0);
    chk("flush.we2", 64'(we2), 64'd0);
    chk("flush.inflight2", 64'(n2), 64'd0);
    chk("flush.wr2_held", 64'(r2), 64'hA1);
    chk("flush.inflight3", 64'(n3), 64'd0);
    chk("flush.wvalid1", 64'(v1), 64'd0);
    @(negedge clk);
    stall = 1'b0; flush = 1'b0; mvalid = 1'b0; mwreg = 1'b0;
    @(posedge clk); #1;
    chk("postflush.wvalid2", 64'(v2), 64'd0);
    chk("postflush.wr2", 64'(r2), 64'hA2);

    // Asynchronous reset between edges with two valid ops in flight.
    drv(1'b1, 1'b1, 1'b0, 5'd3, 32'h77, 32'd0, 1'b0);
    drv(1'b1, 1'b1, 1'b1, 5'd4, 32'h88, 32'h99, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst.inflight2", 64'(n2), 64'd2);
    @(negedge clk);
    mvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.wvalid2", 64'(v2), 64'd0);
    chk("arst.wr2", 64'(r2), 64'd0);
    chk("arst.wdata2", 64'(wd2), 64'd0);
    chk("arst.we2", 64'(we2), 64'd0);
    chk("arst.inflight2", 64'(n2), 64'd0);
    chk("arst.dest2", 64'(d2), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("arst.after_edge_wvalid2", 64'(v2), 64'd0);

`ifdef MWB_HAZARD_EN
    @(negedge clk);
    rs = 5'd9; rt = 5'd4;
    drv(1'b1, 1'b1, 1'b0, 5'd9, 32'h1, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("haz.hit_rs", 64'(h2s), 64'd1);
    chk("haz.hit_rt", 64'(h2t), 64'd0);
    @(negedge clk);
    flush = 1'b1; mvalid = 1'b0;
    @(posedge clk); #1;
    chk("haz.flush_hit_rs", 64'(h2s), 64'd0);
    @(negedge clk);
    flush = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
